// File: rtl/esp32_spi_btn_slave_if.sv
// SPI pin bundle shared between the ESP32 (master) and the button/LED slave.
interface esp32_spi_btn_slave_if;
    logic spi_csn;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_csn, spi_clk, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_csn, spi_clk, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/esp32_spi_btn_slave.sv
// Mode-0 SPI slave in clk_25mhz: debounced buttons + sticky change flag read out, LED register written.
// Define SPI_IRQ_EN to add the registered irq output mirroring the change flag.
module esp32_spi_btn_slave #(
    parameter int C_debounce_bits = 16,
    parameter int C_btn_width     = 7
) (
    input  logic                   clk_25mhz,
    input  logic                   reset,
    input  logic [C_btn_width-1:0] btn,
    esp32_spi_btn_slave_if.slave   spi,
    output logic [C_btn_width-1:0] btn_db,
    output logic [7:0]             led,
    output logic [7:0]             rx_byte,
`ifdef SPI_IRQ_EN
    output logic                   irq,
`endif
    output logic                   rx_valid
);
    typedef enum logic [1:0] {IDLE, CMD, WDATA, DUMMY} state_t;

    localparam logic [C_debounce_bits-1:0] CNT_ONE = 1;

    state_t state, state_n;

    logic csn_p0, csn_p1, csn_p2;
    logic sck_p0, sck_p1, sck_p2;
    logic mosi_p0, mosi_p1;

    logic [C_debounce_bits-1:0] tick_cnt;
    logic [C_btn_width-1:0]     btn_p0, btn_p1, hist_p0, hist_p1, btn_db_n;
    logic                       tick, db_set, changed;

    logic [2:0] bitcnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift, rx_word, status;
    logic       csn_fall, sck_rise, sck_fall, active, byte_done;
    logic       rx_stb, led_we, status_done;

    // Stage p0/p1: metastability filter; p2: previous level for edge detect
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            {csn_p0, csn_p1, csn_p2} <= 3'b111;
            {sck_p0, sck_p1, sck_p2} <= 3'b000;
            {mosi_p0, mosi_p1}       <= 2'b00;
            btn_p0                   <= '0;
            btn_p1                   <= '0;
        end else begin
            {csn_p0, csn_p1, csn_p2} <= {spi.spi_csn, csn_p0, csn_p1};
            {sck_p0, sck_p1, sck_p2} <= {spi.spi_clk, sck_p0, sck_p1};
            {mosi_p0, mosi_p1}       <= {spi.spi_mosi, mosi_p0};
            btn_p0                   <= btn;
            btn_p1                   <= btn_p0;
        end
    end

    assign csn_fall  = csn_p2 & ~csn_p1;
    assign sck_rise  = sck_p1 & ~sck_p2;
    assign sck_fall  = ~sck_p1 & sck_p2;
    assign active    = (state != IDLE) && !csn_p1;
    assign byte_done = active && sck_rise && (bitcnt == 3'd7);
    assign rx_word   = {rx_shift, mosi_p1};

    // A level counts only once the new sample and the two before it agree
    assign tick     = &tick_cnt;
    assign btn_db_n = (btn_db | (btn_p1 & hist_p0 & hist_p1)) & ~(~btn_p1 & ~hist_p0 & ~hist_p1);
    assign db_set   = tick && (btn_db_n != btn_db);

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            hist_p0  <= '0;
            hist_p1  <= '0;
            btn_db   <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_ONE;
            if (tick) begin
                hist_p0 <= btn_p1;
                hist_p1 <= hist_p0;
                btn_db  <= btn_db_n;
            end
        end
    end

    always_comb begin
        status                  = '0;
        status[C_btn_width-1:0] = btn_db;
        status[7]               = changed;
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        rx_stb      = 1'b0;
        led_we      = 1'b0;
        status_done = 1'b0;
        case (state)
            IDLE:  if (csn_fall) state_n = CMD;
            CMD:   if (byte_done) begin
                rx_stb      = 1'b1;
                status_done = 1'b1;
                state_n     = (rx_word == 8'h01) ? WDATA : DUMMY;
            end
            WDATA: if (byte_done) begin
                rx_stb  = 1'b1;
                led_we  = 1'b1;
                state_n = DUMMY;
            end
            DUMMY: if (byte_done) rx_stb = 1'b1;
            default: state_n = IDLE;
        endcase
        if (state != IDLE && csn_p1) state_n = IDLE;
    end

    // After the 8th rising edge the bit counter is back at 0, so the next fall starts a fresh 0x00 byte
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            bitcnt   <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else if (state == IDLE) begin
            if (csn_fall) begin
                tx_shift <= status;
                bitcnt   <= '0;
            end
        end else if (active) begin
            if (sck_rise) begin
                bitcnt   <= bitcnt + 3'd1;
                rx_shift <= rx_word[6:0];
            end
            if (sck_fall) tx_shift <= (bitcnt == 3'd0) ? 8'h00 : {tx_shift[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            led      <= '0;
            changed  <= 1'b0;
        end else begin
            rx_valid <= rx_stb;
            if (rx_stb) rx_byte <= rx_word;
            if (led_we) led <= rx_word;
            if (db_set)           changed <= 1'b1;
            else if (status_done) changed <= 1'b0;
        end
    end

`ifdef SPI_IRQ_EN
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= changed;
    end
`endif

    assign spi.spi_miso    = tx_shift[7];
    assign spi.spi_miso_oe = ~csn_p1;

endmodule
